// File: rtl/ex_mem_pipeline_reg.sv
// ex_mem_pipeline_reg: EX->MEM pipeline register with stall/flush, valid bit, alignment check and optional stats
module ex_mem_pipeline_reg #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5,
  parameter int CNTW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_m,
  input  logic               flush_m,
  input  logic               valid_e,
  input  logic [XLEN-1:0]    alu_result_e,
  input  logic [XLEN-1:0]    write_data_e,
  input  logic [2:0]         type_e,
  input  logic               mem_write_e,
  input  logic               mem_read_e,
  input  logic               reg_write_e,
  input  logic [1:0]         result_src_e,
  input  logic [REGADDR-1:0] rd_e,
  input  logic [XLEN-1:0]    pc_plus4_e,
  output logic               valid_m,
  output logic [XLEN-1:0]    alu_result_m,
  output logic [XLEN-1:0]    write_data_m,
  output logic [2:0]         type_m,
  output logic               mem_write_m,
  output logic               reg_write_m,
  output logic [1:0]         result_src_m,
  output logic [REGADDR-1:0] rd_m,
  output logic [XLEN-1:0]    pc_plus4_m,
  output logic               misalign_m,
  output logic               fwd_valid_m
`ifdef MEM_STATS_EN
  ,
  output logic [CNTW-1:0]    load_cnt,
  output logic [CNTW-1:0]    store_cnt,
  output logic [CNTW-1:0]    bubble_cnt,
  output logic [CNTW-1:0]    misalign_cnt
`endif
);
  typedef struct packed {
    logic               valid;
    logic               mw;
    logic               mr;
    logic               rw;
    logic               mis;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    wd;
    logic [XLEN-1:0]    pc4;
    logic [2:0]         typ;
    logic [1:0]         rs;
    logic [REGADDR-1:0] rd;
  } stage_t;
  stage_t q, d;
  logic mem_e, mis_e;
  always_comb begin
    mem_e = valid_e & (mem_write_e | mem_read_e);
    mis_e = mem_e & ((type_e[1:0] == 2'b11) | (type_e[1] & |alu_result_e[1:0]) | (type_e[0] & alu_result_e[0]));
    d = '0;
    if (!flush_m)
      d = '{valid: valid_e, mw: valid_e & mem_write_e, mr: valid_e & mem_read_e, rw: valid_e & reg_write_e,
            mis: mis_e, alu: alu_result_e, wd: write_data_e, pc4: pc_plus4_e, typ: type_e,
            rs: result_src_e, rd: rd_e};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (!stall_m) q <= d;
  assign valid_m      = q.valid;
  assign alu_result_m = q.alu;
  assign write_data_m = q.wd;
  assign type_m       = q.typ;
  assign result_src_m = q.rs;
  assign rd_m         = q.rd;
  assign pc_plus4_m   = q.pc4;
  assign misalign_m   = q.mis;
  assign mem_write_m  = q.mw & q.valid & ~q.mis;
  assign reg_write_m  = q.rw & q.valid & ~q.mis;
  assign fwd_valid_m  = reg_write_m & (q.rd != '0) & ~q.mr;
`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load_cnt     <= '0;
      store_cnt    <= '0;
      bubble_cnt   <= '0;
      misalign_cnt <= '0;
    end else if (!stall_m) begin
      load_cnt     <= load_cnt + CNTW'(d.mr);
      store_cnt    <= store_cnt + CNTW'(d.mw);
      bubble_cnt   <= bubble_cnt + CNTW'(!d.valid);
      misalign_cnt <= misalign_cnt + CNTW'(d.mis);
    end
`endif
endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// tb_ex_mem_pipeline_reg: vector table with scoreboard queue plus reset and counter sequences
module tb_ex_mem_pipeline_reg;
  logic clk = 0, rst_n = 0, stall_m = 0, flush_m = 0, valid_e = 0;
  logic [31:0] alu_result_e = 0, write_data_e = 0, pc_plus4_e = 0;
  logic [2:0] type_e = 0;
  logic mem_write_e = 0, mem_read_e = 0, reg_write_e = 0;
  logic [1:0] result_src_e = 0;
  logic [4:0] rd_e = 0;
  logic valid_m, mem_write_m, reg_write_m, misalign_m, fwd_valid_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [2:0] type_m;
  logic [1:0] result_src_m;
  logic [4:0] rd_m;
`ifdef MEM_STATS_EN
  logic [3:0] load_cnt, store_cnt, bubble_cnt, misalign_cnt;
`endif
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipeline_reg #(.CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m), .valid_e(valid_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .type_e(type_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .reg_write_e(reg_write_e),
    .result_src_e(result_src_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .valid_m(valid_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .type_m(type_m), .mem_write_m(mem_write_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m),
    .misalign_m(misalign_m), .fwd_valid_m(fwd_valid_m)
`ifdef MEM_STATS_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .bubble_cnt(bubble_cnt), .misalign_cnt(misalign_cnt)
`endif
  );

  typedef struct {
    logic st, fl, v;
    logic [31:0] a, w;
    logic [2:0] t;
    logic mw, mr, rw;
    logic [1:0] rs;
    logic [4:0] rd;
    logic [31:0] pc;
    logic [4:0] ectl;
  } vec_t;
  typedef struct {
    logic [4:0] ctl;
    logic [105:0] dat;
  } exp_t;

  vec_t tbl[17];
  exp_t sb[$];
  exp_t last, e, got;
  logic [4:0] act_ctl;
  logic [105:0] act_dat;
  assign act_ctl = {valid_m, mem_write_m, reg_write_m, misalign_m, fwd_valid_m};
  assign act_dat = {alu_result_m, write_data_m, type_m, result_src_m, rd_m, pc_plus4_m};

  task automatic check(input string nm, input int idx, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, a, x);
    end
  endtask

  task automatic drive(input vec_t r);
    stall_m = r.st; flush_m = r.fl; valid_e = r.v;
    alu_result_e = r.a; write_data_e = r.w; type_e = r.t;
    mem_write_e = r.mw; mem_read_e = r.mr; reg_write_e = r.rw;
    result_src_e = r.rs; rd_e = r.rd; pc_plus4_e = r.pc;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 1, 'h100,  'hDEADBEEF, 3'b010, 1, 0, 0, 2'b00, 0, 'h1004, 5'b11000};
    tbl[1]  = '{0, 0, 1, 'h103,  'h11112222, 3'b001, 1, 0, 0, 2'b00, 0, 'h1008, 5'b10010};
    tbl[2]  = '{0, 0, 1, 'h103,  'h00000033, 3'b000, 1, 0, 0, 2'b00, 0, 'h100c, 5'b11000};
    tbl[3]  = '{1, 0, 1, 'h400,  'h00005555, 3'b010, 0, 0, 1, 2'b00, 7, 'h1010, 5'b00000};
    tbl[4]  = '{1, 0, 1, 'h404,  'h00006666, 3'b010, 1, 0, 0, 2'b00, 0, 'h1014, 5'b00000};
    tbl[5]  = '{1, 0, 0, 'h408,  'h00007777, 3'b001, 0, 1, 1, 2'b01, 9, 'h1018, 5'b00000};
    tbl[6]  = '{0, 1, 1, 'h500,  'h00008888, 3'b010, 1, 0, 1, 2'b00, 3, 'h101c, 5'b00000};
    tbl[7]  = '{0, 0, 1, 'h200,  'h00000000, 3'b010, 0, 1, 1, 2'b01, 5, 'h1020, 5'b10100};
    tbl[8]  = '{0, 0, 1, 'h1234, 'h00000000, 3'b000, 0, 0, 1, 2'b00, 5, 'h1024, 5'b10101};
    tbl[9]  = '{0, 0, 1, 'h1234, 'h00000000, 3'b000, 0, 0, 1, 2'b00, 0, 'h1028, 5'b10100};
    tbl[10] = '{0, 0, 1, 'h202,  'h00000000, 3'b010, 0, 1, 1, 2'b01, 6, 'h102c, 5'b10010};
    tbl[11] = '{0, 0, 1, 'h201,  'h00000000, 3'b101, 0, 1, 1, 2'b01, 7, 'h1030, 5'b10010};
    tbl[12] = '{0, 0, 1, 'h000,  'h0000ABCD, 3'b011, 1, 0, 0, 2'b00, 0, 'h1034, 5'b10010};
    tbl[13] = '{1, 1, 1, 'h300,  'h00000001, 3'b010, 1, 0, 1, 2'b00, 4, 'h1038, 5'b00000};
    tbl[14] = '{0, 0, 0, 'h304,  'h00000002, 3'b010, 1, 1, 1, 2'b00, 4, 'h103c, 5'b00000};
    tbl[15] = '{0, 0, 1, 'h102,  'h0000BEEF, 3'b001, 1, 0, 0, 2'b00, 0, 'h1040, 5'b11000};
    tbl[16] = '{0, 0, 1, 'h003,  'h00000000, 3'b011, 0, 0, 1, 2'b00, 3, 'h1044, 5'b10101};
    #2;
    check("rst_ctl", 0, 128'(act_ctl), 128'd0);
    check("rst_dat", 0, 128'(act_dat), 128'd0);
    @(negedge clk) rst_n = 1;
    last = '{ctl: '0, dat: '0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      if (tbl[i].st) e = last;
      else if (tbl[i].fl) e = '{ctl: '0, dat: '0};
      else e = '{ctl: tbl[i].ectl, dat: {tbl[i].a, tbl[i].w, tbl[i].t, tbl[i].rs, tbl[i].rd, tbl[i].pc}};
      sb.push_back(e);
      last = e;
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("ctl", i, 128'(act_ctl), 128'(got.ctl));
      check("dat", i, 128'(act_dat), 128'(got.dat));
    end
    @(negedge clk);
    drive(tbl[0]);
    @(posedge clk);
    #1 check("pre_rst_mw", 0, 128'(mem_write_m), 128'd1);
    #2 rst_n = 0;
    #1;
    check("async_rst_ctl", 0, 128'(act_ctl), 128'd0);
    check("async_rst_dat", 0, 128'(act_dat), 128'd0);
    @(negedge clk);
    drive('{0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 5'b00000});
    rst_n = 1;
    @(posedge clk);
    #1;
    check("post_rst_ctl", 0, 128'(act_ctl), 128'd0);
    check("post_rst_dat", 0, 128'(act_dat), 128'd0);
`ifdef MEM_STATS_EN
    @(negedge clk) rst_n = 0;
    drive('{0, 0, 1, 'h100, 'h1, 3'b010, 1, 0, 0, 2'b00, 0, 'h4, 5'b00000});
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      stall_m = (i % 7 == 3);
      @(posedge clk);
      @(negedge clk);
    end
    stall_m = 0;
    check("store_wrap", 0, 128'(store_cnt), 128'd1);
    check("load_none", 0, 128'(load_cnt), 128'd0);
    drive('{0, 0, 1, 'h201, 'h0, 3'b010, 0, 1, 1, 2'b01, 5, 'h8, 5'b00000});
    @(posedge clk);
    @(negedge clk);
    valid_e = 0;
    @(posedge clk);
    @(negedge clk);
    check("load_cnt", 0, 128'(load_cnt), 128'd1);
    check("misalign_cnt", 0, 128'(misalign_cnt), 128'd1);
    check("bubble_cnt", 0, 128'(bubble_cnt), 128'd1);
    check("store_hold", 0, 128'(store_cnt), 128'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
